// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline hazard controller.
//   fwd_sel_e    - forward select: register file / writeback / memory stage
//   state_e      - hazard FSM states
//   DRAIN_CYCLES - cycles spent draining before entering HALTED
//   sat_inc      - 16-bit saturating increment for the perf counters
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_DRAIN    = 2'b10,
    ST_HALTED   = 2'b11
  } state_e;

  localparam int unsigned DRAIN_CYCLES = 3;
  localparam logic [1:0]  DRAIN_INIT   = 2'(DRAIN_CYCLES);

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != '1)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// fwd_select: picks the operand source for one execute-stage register.
//   src        - register index read in execute
//   en         - qualifier; when low the select is always the register file
//   rd_m/wb_m  - memory-stage destination and write-enable
//   rd_w/wb_w  - writeback-stage destination and write-enable
//   sel        - FWD_MEM if memory stage matches, else FWD_WB, else FWD_RF
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] src,
  input  logic       en,
  input  logic [3:0] rd_m,
  input  logic       wb_m,
  input  logic [3:0] rd_w,
  input  logic       wb_w,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (en) begin
      if (wb_m && (rd_m == src))      sel = FWD_MEM;
      else if (wb_w && (rd_w == src)) sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, stall/flush control and halt sequencing
// for a 5-stage pipeline.
//   clk, rst (sync, active-high)
//   decode : rs1_D, rs2_D, use1_D, use2_D
//   execute: rs1_E, rs2_E, rd_E, wb_E, ld_E, st_E, branch_taken_E
//   memory : rd_M, wb_M, mem_busy
//   wback  : rd_W, wb_W
//   control: halt_req, resume
//   outputs: fwd_a_E/fwd_b_E/fwd_st_E forward selects; stall_F/D/E/M,
//            bubble_E, flush_D, halted; stall_cnt/flush_cnt perf counters
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rs1_D,
  input  logic [3:0]  rs2_D,
  input  logic        use1_D,
  input  logic        use2_D,
  input  logic [3:0]  rs1_E,
  input  logic [3:0]  rs2_E,
  input  logic [3:0]  rd_E,
  input  logic        wb_E,
  input  logic        ld_E,
  input  logic        st_E,
  input  logic        branch_taken_E,
  input  logic [3:0]  rd_M,
  input  logic        wb_M,
  input  logic        mem_busy,
  input  logic [3:0]  rd_W,
  input  logic        wb_W,
  input  logic        halt_req,
  input  logic        resume,
  output logic [1:0]  fwd_a_E,
  output logic [1:0]  fwd_b_E,
  output logic [1:0]  fwd_st_E,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        stall_M,
  output logic        bubble_E,
  output logic        flush_D,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  state_e      state_q, state_d;
  logic [1:0]  drain_q, drain_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        load_use;
  logic        br_flush;

  fwd_select u_fwd_a (
    .src(rs1_E), .en(1'b1), .rd_m(rd_M), .wb_m(wb_M), .rd_w(rd_W), .wb_w(wb_W), .sel(fwd_a_E)
  );
  fwd_select u_fwd_b (
    .src(rs2_E), .en(1'b1), .rd_m(rd_M), .wb_m(wb_M), .rd_w(rd_W), .wb_w(wb_W), .sel(fwd_b_E)
  );
  fwd_select u_fwd_st (
    .src(rd_E), .en(st_E), .rd_m(rd_M), .wb_m(wb_M), .rd_w(rd_W), .wb_w(wb_W), .sel(fwd_st_E)
  );

  always_comb begin
    load_use = ld_E && wb_E &&
               ((use1_D && (rd_E == rs1_D)) || (use2_D && (rd_E == rs2_D)));

    state_d  = state_q;
    drain_d  = drain_q;
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_E  = 1'b0;
    stall_M  = 1'b0;
    bubble_E = 1'b0;
    flush_D  = 1'b0;
    halted   = 1'b0;
    br_flush = 1'b0;

    case (state_q)
      // MEM_WAIT shares RUN's logic: the cycle mem_busy drops already behaves
      // as RUN, so the stall lasts exactly as long as mem_busy. halt_req is
      // only honoured from RUN proper.
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_busy) begin
          {stall_F, stall_D, stall_E, stall_M} = '1;
          state_d = ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
          if ((state_q == ST_RUN) && halt_req) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_INIT;
          end
          if (branch_taken_E) begin
            flush_D  = 1'b1;
            bubble_E = 1'b1;
            br_flush = 1'b1;
          end else if (load_use) begin
            stall_F  = 1'b1;
            stall_D  = 1'b1;
            bubble_E = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        stall_F = 1'b1;
        flush_D = 1'b1;
        if (mem_busy) begin
          {stall_D, stall_E, stall_M} = '1;
        end else if (drain_q <= 2'd1) begin
          drain_d = '0;
          state_d = ST_HALTED;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      ST_HALTED: begin
        halted  = 1'b1;
        stall_F = 1'b1;
        flush_D = 1'b1;
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    stall_cnt_d = sat_inc(stall_cnt_q, stall_D);
    flush_cnt_d = sat_inc(flush_cnt_q, br_flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic        use1_D, use2_D, wb_E, ld_E, st_E, branch_taken_E;
  logic        wb_M, mem_busy, wb_W, halt_req, resume;
  logic [1:0]  fwd_a_E, fwd_b_E, fwd_st_E;
  logic        stall_F, stall_D, stall_E, stall_M, bubble_E, flush_D, halted;
  logic [15:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .use1_D(use1_D), .use2_D(use2_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .wb_E(wb_E), .ld_E(ld_E), .st_E(st_E),
    .branch_taken_E(branch_taken_E),
    .rd_M(rd_M), .wb_M(wb_M), .mem_busy(mem_busy),
    .rd_W(rd_W), .wb_W(wb_W),
    .halt_req(halt_req), .resume(resume),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .fwd_st_E(fwd_st_E),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .bubble_E(bubble_E), .flush_D(flush_D), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic [3:0] rs1_d, rs2_d;
    logic       use1_d, use2_d;
    logic [3:0] rs1_e, rs2_e, rd_e;
    logic       wb_e, ld_e, st_e, br;
    logic [3:0] rd_m;
    logic       wb_m, busy;
    logic [3:0] rd_w;
    logic       wb_w, halt, res;
  } in_t;

  // ctl = {stall_F, stall_D, stall_E, stall_M, bubble_E, flush_D, halted}
  typedef struct packed {
    logic [1:0] fa, fb, fs;
    logic [6:0] ctl;
    logic       cnt_flush;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  localparam logic [6:0] C_IDLE     = 7'b0000000;
  localparam logic [6:0] C_LU       = 7'b1100100;
  localparam logic [6:0] C_BR       = 7'b0000110;
  localparam logic [6:0] C_MEM      = 7'b1111000;
  localparam logic [6:0] C_DRAIN    = 7'b1000010;
  localparam logic [6:0] C_DRAIN_MB = 7'b1111010;
  localparam logic [6:0] C_HALT     = 7'b1000011;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [15:0] model_stall = '0;
  logic [15:0] model_flush = '0;
  exp_t        exp_q[$];

  function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] fs,
                              input logic [6:0] ctl, input logic cf);
    exp_t e;
    e.fa = fa; e.fb = fb; e.fs = fs; e.ctl = ctl; e.cnt_flush = cf;
    return e;
  endfunction

  task automatic drive(input in_t i);
    rs1_D = i.rs1_d; rs2_D = i.rs2_d; use1_D = i.use1_d; use2_D = i.use2_d;
    rs1_E = i.rs1_e; rs2_E = i.rs2_e; rd_E = i.rd_e;
    wb_E = i.wb_e; ld_E = i.ld_e; st_E = i.st_e; branch_taken_E = i.br;
    rd_M = i.rd_m; wb_M = i.wb_m; mem_busy = i.busy;
    rd_W = i.rd_w; wb_W = i.wb_w; halt_req = i.halt; resume = i.res;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
  task automatic step(input string tag, input in_t i, input exp_t e);
    exp_t x;
    drive(i);
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    chk({tag, ".fwd_a"},  {14'd0, fwd_a_E},  {14'd0, x.fa});
    chk({tag, ".fwd_b"},  {14'd0, fwd_b_E},  {14'd0, x.fb});
    chk({tag, ".fwd_st"}, {14'd0, fwd_st_E}, {14'd0, x.fs});
    chk({tag, ".ctl"}, {9'd0, stall_F, stall_D, stall_E, stall_M, bubble_E, flush_D, halted},
        {9'd0, x.ctl});
    chk({tag, ".stall_cnt"}, stall_cnt, model_stall);
    chk({tag, ".flush_cnt"}, flush_cnt, model_flush);
    if (x.ctl[5] && (model_stall != 16'hFFFF)) model_stall++;
    if (x.cnt_flush && (model_flush != 16'hFFFF)) model_flush++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(in_t'('0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_stall = '0;
    model_flush = '0;
  endtask

  vec_t tbl[14];
  in_t  t;
  in_t  z;

  initial begin
    z = '0;
    rst = 1'b1;
    drive(z);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Forwarding priority: memory stage beats writeback
    t = z; t.rs1_e = 4'd5; t.wb_m = 1; t.rd_m = 4'd5; t.wb_w = 1; t.rd_w = 4'd5;
    tbl[0] = '{t, mk(2'b10, 2'b00, 2'b00, C_IDLE, 0)};
    t.wb_m = 0;
    tbl[1] = '{t, mk(2'b01, 2'b00, 2'b00, C_IDLE, 0)};
    t = z; t.rs2_e = 4'd7; t.rd_m = 4'd7; t.wb_w = 1; t.rd_w = 4'd7;
    tbl[2] = '{t, mk(2'b00, 2'b01, 2'b00, C_IDLE, 0)};
    t = z; t.st_e = 1; t.rd_e = 4'd9; t.rd_m = 4'd9; t.wb_m = 1;
    tbl[3] = '{t, mk(2'b00, 2'b00, 2'b10, C_IDLE, 0)};
    t.st_e = 0;
    tbl[4] = '{t, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0)};
    t = z; t.st_e = 1; t.rd_e = 4'd9; t.rd_w = 4'd9; t.wb_w = 1;
    tbl[5] = '{t, mk(2'b00, 2'b00, 2'b01, C_IDLE, 0)};
    t = z; t.rs1_e = 4'd4; t.rd_m = 4'd4; t.rd_w = 4'd4;
    tbl[6] = '{t, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0)};
    // Load-use detection
    t = z; t.ld_e = 1; t.wb_e = 1; t.rd_e = 4'd3; t.rs2_d = 4'd3; t.use2_d = 1;
    tbl[7] = '{t, mk(2'b00, 2'b00, 2'b00, C_LU, 0)};
    t.use2_d = 0;
    tbl[8] = '{t, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0)};
    t.rs1_d = 4'd3; t.use1_d = 1;
    tbl[9] = '{t, mk(2'b00, 2'b00, 2'b00, C_LU, 0)};
    t.wb_e = 0;
    tbl[10] = '{t, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0)};
    // Branch wins over load-use; branch alone
    t = z; t.ld_e = 1; t.wb_e = 1; t.rd_e = 4'd3; t.rs2_d = 4'd3; t.use2_d = 1; t.br = 1;
    tbl[11] = '{t, mk(2'b00, 2'b00, 2'b00, C_BR, 1)};
    t = z; t.br = 1;
    tbl[12] = '{t, mk(2'b00, 2'b00, 2'b00, C_BR, 1)};
    // resume outside HALTED does nothing
    t = z; t.res = 1;
    tbl[13] = '{t, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0)};

    step("reset", z, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0));
    for (int k = 0; k < 14; k++) step($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);

    // Memory wait for 4 cycles; halt_req and branch during the wait are ignored
    for (int k = 0; k < 4; k++) begin
      t = z; t.busy = 1; t.halt = (k == 1 || k == 2); t.br = (k == 2);
      step($sformatf("memwait%0d", k), t, mk(2'b00, 2'b00, 2'b00, C_MEM, 0));
    end
    step("memwait_exit", z, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0));
    t = z; t.br = 1;
    step("memwait_run", t, mk(2'b00, 2'b00, 2'b00, C_BR, 1));

    // Halt: 3 drain cycles, then HALTED until resume
    t = z; t.halt = 1;
    step("halt_req", t, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0));
    for (int k = 0; k < 3; k++) begin
      t = z; t.br = (k == 1); t.res = (k == 2);
      step($sformatf("drain%0d", k), t, mk(2'b00, 2'b00, 2'b00, C_DRAIN, 0));
    end
    step("halted0", z, mk(2'b00, 2'b00, 2'b00, C_HALT, 0));
    t = z; t.br = 1;
    step("halted1", t, mk(2'b00, 2'b00, 2'b00, C_HALT, 0));
    t = z; t.res = 1;
    step("resume", t, mk(2'b00, 2'b00, 2'b00, C_HALT, 0));
    step("after_resume", z, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0));

    // Drain frozen by mem_busy, then continues
    t = z; t.halt = 1;
    step("halt2_req", t, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0));
    step("drain_a", z, mk(2'b00, 2'b00, 2'b00, C_DRAIN, 0));
    t = z; t.busy = 1;
    step("drain_busy0", t, mk(2'b00, 2'b00, 2'b00, C_DRAIN_MB, 0));
    step("drain_busy1", t, mk(2'b00, 2'b00, 2'b00, C_DRAIN_MB, 0));
    step("drain_b", z, mk(2'b00, 2'b00, 2'b00, C_DRAIN, 0));
    step("drain_c", z, mk(2'b00, 2'b00, 2'b00, C_DRAIN, 0));
    step("halted2", z, mk(2'b00, 2'b00, 2'b00, C_HALT, 0));
    t = z; t.res = 1;
    step("resume2", t, mk(2'b00, 2'b00, 2'b00, C_HALT, 0));

    // Reset mid-MEM_WAIT
    t = z; t.busy = 1;
    step("mw_rst0", t, mk(2'b00, 2'b00, 2'b00, C_MEM, 0));
    step("mw_rst1", t, mk(2'b00, 2'b00, 2'b00, C_MEM, 0));
    do_reset();
    step("mw_after_rst", z, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0));

    // Reset mid-DRAIN: both counters non-zero beforehand
    t = z; t.br = 1;
    step("pre_rst_br", t, mk(2'b00, 2'b00, 2'b00, C_BR, 1));
    t = z; t.ld_e = 1; t.wb_e = 1; t.rd_e = 4'd6; t.rs1_d = 4'd6; t.use1_d = 1;
    step("pre_rst_lu", t, mk(2'b00, 2'b00, 2'b00, C_LU, 0));
    t = z; t.halt = 1;
    step("halt3_req", t, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0));
    step("drain_rst", z, mk(2'b00, 2'b00, 2'b00, C_DRAIN, 0));
    do_reset();
    step("dr_after_rst0", z, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0));
    step("dr_after_rst1", z, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0));
    step("dr_after_rst2", z, mk(2'b00, 2'b00, 2'b00, C_IDLE, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have these ports: clk input 1 clock; rst input 1 reset, synchronous, active-high.
REQ-002 SHALL have decode-stage ports: rs1_D, rs2_D input 4 each, source registers; use1_D, use2_D input 1 each, source-used flags.
REQ-003 SHALL have execute-stage ports: rs1_E, rs2_E, rd_E input 4 each; wb_E, ld_E, st_E input 1 each; branch_taken_E input 1, resolved taken branch.
REQ-004 SHALL have memory-stage ports: rd_M input 4; wb_M input 1; mem_busy input 1, memory not ready this cycle.
REQ-005 SHALL have writeback-stage ports: rd_W input 4; wb_W input 1.
REQ-006 SHALL have control inputs halt_req and resume, 1 bit each.
REQ-007 SHALL drive fwd_a_E, fwd_b_E and fwd_st_E, 2 bits each: operand-A, operand-B and store-data forward selects.
REQ-008 SHALL drive these 1-bit outputs: stall_F, stall_D, stall_E, stall_M, bubble_E, flush_D and halted.
REQ-009 SHALL drive stall_cnt and flush_cnt, 16 bits each, as performance counters.

Function
REQ-010 Forward encoding SHALL be: 00 register file, 01 writeback result, 10 memory-stage result.
REQ-011 fwd_a_E SHALL be 10 if wb_M and rd_M==rs1_E, else 01 if wb_W and rd_W==rs1_E, else 00. Memory stage wins when both stages match.
REQ-012 fwd_b_E SHALL follow the REQ-011 rule using rs2_E.
REQ-013 fwd_st_E SHALL follow the REQ-011 rule using rd_E, qualified by st_E, and SHALL be 00 when st_E=0.
REQ-014 Load-use SHALL be detected when ld_E and wb_E are both set and rd_E equals either rs1_D with use1_D set or rs2_D with use2_D set.
REQ-015 A load-use hazard SHALL assert stall_F, stall_D and bubble_E for exactly one cycle, in the cycle it is detected.
REQ-016 branch_taken_E SHALL assert flush_D and bubble_E in the same cycle, with no stall.
REQ-017 FSM states SHALL be RUN, MEM_WAIT, DRAIN and HALTED.
REQ-018 RUN transitions SHALL be checked in this priority order:
- mem_busy leads to MEM_WAIT;
- halt_req leads to DRAIN, with the drain counter loaded to 3;
- otherwise the FSM stays in RUN.
REQ-019 In MEM_WAIT, all four stall outputs SHALL be 1 and bubble_E/flush_D SHALL be 0. The FSM SHALL return to RUN in the first cycle mem_busy samples 0.
REQ-020 In DRAIN, stall_F and flush_D SHALL be 1 every cycle. The counter SHALL decrement each cycle, and the FSM SHALL enter HALTED when the counter reaches 0.
REQ-021 In DRAIN, mem_busy SHALL freeze the counter and assert all stalls; the drain SHALL continue after mem_busy clears.
REQ-022 In HALTED, halted SHALL be 1, stall_F and flush_D SHALL be 1, and all other controls SHALL be 0. resume SHALL return the FSM to RUN.
REQ-023 In RUN, the combinational priority for one cycle SHALL be: mem_busy, then branch_taken_E, then load-use. When a branch and load-use coincide, the flush SHALL win and there SHALL be no stall.
REQ-024 Forward selects SHALL be valid in every state; they are combinational from current inputs.
REQ-025 stall_cnt SHALL increment in any cycle where stall_D=1.
REQ-026 flush_cnt SHALL increment in any cycle where flush_D=1 due to branch_taken_E.
REQ-027 Both counters SHALL saturate at 16'hFFFF.
REQ-028 halt_req arriving while in MEM_WAIT SHALL be ignored. resume arriving outside HALTED SHALL be ignored.

Reset
REQ-029 On rst, the FSM SHALL go to RUN, with the drain counter at 0 and both perf counters at 0. All stall, bubble, flush and halted outputs SHALL be 0 in the following cycle.
REQ-030 rst asserted mid-DRAIN or mid-MEM_WAIT SHALL abort to RUN with no pending state.

Structure
REQ-031 The forward-select encodings (00/01/10), the FSM state encodings and DRAIN_CYCLES=3 SHALL reside in the shared package pipe_ctrl_pkg.
REQ-032 One sub-module, fwd_select, SHALL implement the REQ-011 comparison and SHALL be instantiated three times.

Verification
REQ-033 The bench SHALL cover forwarding priority: with rs1_E=5, wb_M=1, rd_M=5, wb_W=1 and rd_W=5, fwd_a_E SHALL be 10; after clearing wb_M, fwd_a_E SHALL be 01.
REQ-034 The bench SHALL cover load-use: with ld_E=1, wb_E=1, rd_E=3, rs2_D=3 and use2_D=1, stall_F, stall_D and bubble_E SHALL be 1 for one cycle and stall_cnt SHALL reach 1.
REQ-035 The bench SHALL cover branch over load-use: with branch_taken_E=1 during a load-use hazard, flush_D and bubble_E SHALL be 1, stall_D SHALL be 0 and flush_cnt SHALL reach 1.
REQ-036 The bench SHALL cover memory wait: with mem_busy high for 4 cycles, all stalls SHALL be high for 4 cycles and then the FSM SHALL return to RUN.
REQ-037 The bench SHALL cover halt and resume: a halt_req pulse SHALL give 3 DRAIN cycles and then halted=1; a resume pulse SHALL give halted=0 and RUN on the next cycle.
REQ-038 The bench SHALL cover reset mid-drain: rst asserted during DRAIN SHALL leave the FSM in RUN with both counters at 0 on the next cycle.
